axi4_lite_io_slave: RTL and testbench



---
 rtl/axi4_lite_io_slave.sv | 222 ++++++++++++++++++++++
 tb/tb_axi4_lite_io_slave.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_io_slave.sv
// AXI4-Lite slave that owns the LED / seven-segment output registers and a
// reloading down-counter timer that raises a level interrupt on expiry.
module axi4_lite_io_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ADDR_WIDTH-1:0] S_AWADDR,
  input  logic                  S_AWVALID,
  output logic                  S_AWREADY,
  input  logic [DATA_WIDTH-1:0] S_WDATA,
  input  logic [3:0]            S_WSTRB,
  input  logic                  S_WVALID,
  output logic                  S_WREADY,
  input  logic                  S_BREADY,
  output logic                  S_BVALID,
  output logic [1:0]            S_BRESP,
  input  logic [ADDR_WIDTH-1:0] S_ARADDR,
  input  logic                  S_ARVALID,
  output logic                  S_ARREADY,
  input  logic                  S_RREADY,
  output logic [DATA_WIDTH-1:0] S_RDATA,
  output logic                  S_RVALID,
  output logic [1:0]            S_RRESP,
  output logic [7:0]            LED_OUT,
  output logic [7:0]            SEVENSEG_OUT,
  output logic                  IRQ_OUT
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] REG_LED    = 3'd0;
  localparam logic [2:0] REG_SEG    = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_LOAD   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_COUNT  = 3'd5;

  // Write holding buffers (stage p0) and response (stage p1)
  logic                  aw_vld_p0;
  logic [ADDR_WIDTH-1:0] aw_addr_p0;
  logic                  w_vld_p0;
  logic [15:0]           w_data_p0;
  logic [1:0]            w_strb_p0;
  logic                  b_vld_p1;
  logic [1:0]            b_resp_p1;

  // Read response (stage p1)
  logic                  r_vld_p1;
  logic [1:0]            r_resp_p1;
  logic [DATA_WIDTH-1:0] r_data_p1;

  // Architectural registers
  logic [7:0]  led_reg;
  logic [7:0]  seg_reg;
  logic        tmr_en;
  logic        irq_en;
  logic [15:0] load_reg;
  logic [15:0] count_reg;
  logic        expired;
  logic        irq_reg;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic [2:0]            wr_idx;
  logic                  wr_commit;
  logic                  wr_legal;
  logic                  wr_b0;
  logic                  wr_b1;
  logic                  tmr_start;
  logic                  tmr_reload;
  logic                  stat_clr;
  logic                  rd_legal;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_bits;

  // Only word offsets 0x00..0x14 decode; everything above is a hole.
  function automatic logic reg_hit(input logic [ADDR_WIDTH-1:0] a);
    return (a[ADDR_WIDTH-1:5] == '0) && (a[4:2] <= REG_COUNT);
  endfunction

  assign S_AWREADY    = !aw_vld_p0 && !b_vld_p1;
  assign S_WREADY     = !w_vld_p0 && !b_vld_p1;
  assign S_ARREADY    = !r_vld_p1;
  assign S_BVALID     = b_vld_p1;
  assign S_BRESP      = b_resp_p1;
  assign S_RVALID     = r_vld_p1;
  assign S_RRESP      = r_resp_p1;
  assign S_RDATA      = r_data_p1;
  assign LED_OUT      = led_reg;
  assign SEVENSEG_OUT = seg_reg;
  assign IRQ_OUT      = irq_reg;

  assign aw_hs     = S_AWVALID && S_AWREADY;
  assign w_hs      = S_WVALID && S_WREADY;
  assign ar_hs     = S_ARVALID && S_ARREADY;
  assign wr_idx    = aw_addr_p0[4:2];
  assign wr_commit = aw_vld_p0 && w_vld_p0;
  assign wr_legal  = reg_hit(aw_addr_p0) && (wr_idx != REG_COUNT);
  assign wr_b0     = wr_commit && wr_legal && w_strb_p0[0];
  assign wr_b1     = wr_commit && wr_legal && w_strb_p0[1];
  assign rd_legal  = reg_hit(S_ARADDR);

  // Timer control: a 0->1 enable loads the counter; expiry reloads and flags.
  assign tmr_start  = wr_b0 && (wr_idx == REG_CTRL) && w_data_p0[0] && !tmr_en;
  assign tmr_reload = tmr_en && (count_reg == 16'd0) && (load_reg != 16'd0);
  assign stat_clr   = wr_b0 && (wr_idx == REG_STATUS) && w_data_p0[0];

  assign unused_bits = ^{S_WDATA[DATA_WIDTH-1:16], S_WSTRB[3:2],
                         S_ARADDR[1:0], aw_addr_p0[1:0]};

  always_comb begin
    rd_word = '0;
    case (S_ARADDR[4:2])
      REG_LED:    rd_word[7:0]  = led_reg;
      REG_SEG:    rd_word[7:0]  = seg_reg;
      REG_CTRL:   rd_word[1:0]  = {irq_en, tmr_en};
      REG_LOAD:   rd_word[15:0] = load_reg;
      REG_STATUS: rd_word[0]    = expired;
      REG_COUNT:  rd_word[15:0] = count_reg;
      default:    rd_word       = '0;
    endcase
    if (!rd_legal) rd_word = '0;
  end

  // Write address/data capture and write response
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      aw_vld_p0  <= 1'b0;
      aw_addr_p0 <= '0;
      w_vld_p0   <= 1'b0;
      w_data_p0  <= '0;
      w_strb_p0  <= '0;
      b_vld_p1   <= 1'b0;
      b_resp_p1  <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_vld_p0  <= 1'b1;
        aw_addr_p0 <= S_AWADDR;
      end else if (wr_commit) begin
        aw_vld_p0 <= 1'b0;
      end

      if (w_hs) begin
        w_vld_p0  <= 1'b1;
        w_data_p0 <= S_WDATA[15:0];
        w_strb_p0 <= S_WSTRB[1:0];
      end else if (wr_commit) begin
        w_vld_p0 <= 1'b0;
      end

      if (wr_commit) begin
        b_vld_p1  <= 1'b1;
        b_resp_p1 <= wr_legal ? RESP_OKAY : RESP_SLVERR;
      end else if (b_vld_p1 && S_BREADY) begin
        b_vld_p1 <= 1'b0;
      end
    end
  end

  // Read response; data is sampled before any same-edge register write lands
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_vld_p1  <= 1'b0;
      r_resp_p1 <= RESP_OKAY;
      r_data_p1 <= '0;
    end else if (ar_hs) begin
      r_vld_p1  <= 1'b1;
      r_resp_p1 <= rd_legal ? RESP_OKAY : RESP_SLVERR;
      r_data_p1 <= rd_word;
    end else if (r_vld_p1 && S_RREADY) begin
      r_vld_p1 <= 1'b0;
    end
  end

  // Register file
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      led_reg  <= '0;
      seg_reg  <= '0;
      tmr_en   <= 1'b0;
      irq_en   <= 1'b0;
      load_reg <= '0;
    end else begin
      if (wr_b0) begin
        case (wr_idx)
          REG_LED:  led_reg       <= w_data_p0[7:0];
          REG_SEG:  seg_reg       <= w_data_p0[7:0];
          REG_CTRL: {irq_en, tmr_en} <= w_data_p0[1:0];
          REG_LOAD: load_reg[7:0] <= w_data_p0[7:0];
          default:  ;
        endcase
      end
      if (wr_b1 && (wr_idx == REG_LOAD)) load_reg[15:8] <= w_data_p0[15:8];
    end
  end

  // Timer, expiry flag (set beats a simultaneous clear) and interrupt
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      count_reg <= '0;
      expired   <= 1'b0;
      irq_reg   <= 1'b0;
    end else begin
      if (tmr_start) begin
        count_reg <= load_reg;
      end else if (tmr_en) begin
        if (count_reg != 16'd0) count_reg <= count_reg - 16'd1;
        else if (tmr_reload)    count_reg <= load_reg;
      end

      if (tmr_reload)    expired <= 1'b1;
      else if (stat_clr) expired <= 1'b0;

      irq_reg <= expired && irq_en;
    end
  end

endmodule

// File: tb/tb_axi4_lite_io_slave.sv
// Bench for axi4_lite_io_slave: register-map vector table plus hand-built
// sequences for reset, back-pressure, timer expiry and read throughput.
module tb_axi4_lite_io_slave;

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  logic        ACLK;
  logic        ARESETn;
  logic [31:0] S_AWADDR;
  logic        S_AWVALID;
  logic        S_AWREADY;
  logic [31:0] S_WDATA;
  logic [3:0]  S_WSTRB;
  logic        S_WVALID;
  logic        S_WREADY;
  logic        S_BREADY;
  logic        S_BVALID;
  logic [1:0]  S_BRESP;
  logic [31:0] S_ARADDR;
  logic        S_ARVALID;
  logic        S_ARREADY;
  logic        S_RREADY;
  logic [31:0] S_RDATA;
  logic        S_RVALID;
  logic [1:0]  S_RRESP;
  logic [7:0]  LED_OUT;
  logic [7:0]  SEVENSEG_OUT;
  logic        IRQ_OUT;

  axi4_lite_io_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BREADY(S_BREADY), .S_BVALID(S_BVALID), .S_BRESP(S_BRESP),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RREADY(S_RREADY), .S_RDATA(S_RDATA), .S_RVALID(S_RVALID), .S_RRESP(S_RRESP),
    .LED_OUT(LED_OUT), .SEVENSEG_OUT(SEVENSEG_OUT), .IRQ_OUT(IRQ_OUT)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } rexp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  int         n_chk = 0;
  int         n_err = 0;
  logic [1:0] bq[$];
  rexp_t      rq[$];
  rexp_t      mon_r;
  logic [1:0] mon_b;
  vec_t       vt[22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: handshake did not complete", nm);
  endtask

  function automatic rexp_t mk_r(input logic [1:0] r, input logic [31:0] d);
    rexp_t e;
    e.resp = r;
    e.data = d;
    return e;
  endfunction

  // Scoreboard: responses are compared as their handshake completes
  always @(negedge ACLK) begin
    if (S_BVALID && S_BREADY) begin
      if (bq.size() == 0) fail("b_unexpected");
      else begin
        mon_b = bq.pop_front();
        chk("bresp", 32'(S_BRESP), 32'(mon_b));
      end
    end
    if (S_RVALID && S_RREADY) begin
      if (rq.size() == 0) fail("r_unexpected");
      else begin
        mon_r = rq.pop_front();
        chk("rresp", 32'(S_RRESP), 32'(mon_r.resp));
        chk("rdata", S_RDATA, mon_r.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue_wr(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] er);
    bit aw_done, w_done, a_hs, w_hs;
    int t;
    bq.push_back(er);
    S_AWADDR = a; S_WDATA = d; S_WSTRB = s;
    S_AWVALID = 1'b1; S_WVALID = 1'b1;
    aw_done = 0; w_done = 0; t = 0;
    while (!(aw_done && w_done) && t < 50) begin
      @(negedge ACLK);
      a_hs = S_AWVALID && S_AWREADY;
      w_hs = S_WVALID && S_WREADY;
      @(posedge ACLK); #1;
      if (a_hs) begin S_AWVALID = 1'b0; aw_done = 1; end
      if (w_hs) begin S_WVALID = 1'b0; w_done = 1; end
      t++;
    end
    if (!(aw_done && w_done)) begin
      fail("aw_w_timeout");
      S_AWVALID = 1'b0; S_WVALID = 1'b0;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [1:0] er);
    bit done;
    int t;
    issue_wr(a, d, s, er);
    done = 0; t = 0;
    while (!done && t < 50) begin
      @(negedge ACLK);
      done = S_BVALID && S_BREADY;
      @(posedge ACLK); #1;
      t++;
    end
    if (!done) fail("b_timeout");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
    bit hs, done;
    int t;
    rq.push_back(mk_r(er, ed));
    S_ARADDR = a; S_ARVALID = 1'b1;
    done = 0; t = 0;
    while (!done && t < 50) begin
      @(negedge ACLK);
      hs = S_ARREADY;
      @(posedge ACLK); #1;
      if (hs) begin S_ARVALID = 1'b0; done = 1; end
      t++;
    end
    if (!done) begin fail("ar_timeout"); S_ARVALID = 1'b0; end
    done = 0; t = 0;
    while (!done && t < 50) begin
      @(negedge ACLK);
      done = S_RVALID && S_RREADY;
      @(posedge ACLK); #1;
      t++;
    end
    if (!done) fail("r_timeout");
  endtask

  initial begin
    vt[0]  = '{1'b1, 32'h04, 32'h3C,        4'h0, OK,  32'h0};
    vt[1]  = '{1'b0, 32'h04, 32'h0,         4'h0, OK,  32'h0};
    vt[2]  = '{1'b1, 32'h40, 32'hFF,        4'hF, ERR, 32'h0};
    vt[3]  = '{1'b0, 32'h40, 32'h0,         4'h0, ERR, 32'h0};
    vt[4]  = '{1'b1, 32'h0C, 32'h1234,      4'h3, OK,  32'h0};
    vt[5]  = '{1'b0, 32'h0C, 32'h0,         4'h0, OK,  32'h1234};
    vt[6]  = '{1'b1, 32'h0C, 32'hABCD,      4'h2, OK,  32'h0};
    vt[7]  = '{1'b0, 32'h0C, 32'h0,         4'h0, OK,  32'hAB34};
    vt[8]  = '{1'b1, 32'h14, 32'h55,        4'hF, ERR, 32'h0};
    vt[9]  = '{1'b0, 32'h14, 32'h0,         4'h0, OK,  32'h0};
    vt[10] = '{1'b1, 32'h04, 32'hFFFF_FF3C, 4'hF, OK,  32'h0};
    vt[11] = '{1'b0, 32'h04, 32'h0,         4'h0, OK,  32'h3C};
    vt[12] = '{1'b1, 32'h08, 32'hFFFF_FFFE, 4'h1, OK,  32'h0};
    vt[13] = '{1'b0, 32'h08, 32'h0,         4'h0, OK,  32'h2};
    vt[14] = '{1'b1, 32'h08, 32'h0,         4'h1, OK,  32'h0};
    vt[15] = '{1'b0, 32'h08, 32'h0,         4'h0, OK,  32'h0};
    vt[16] = '{1'b0, 32'h10, 32'h0,         4'h0, OK,  32'h0};
    vt[17] = '{1'b0, 32'h03, 32'h0,         4'h0, OK,  32'hA5};
    vt[18] = '{1'b0, 32'h18, 32'h0,         4'h0, ERR, 32'h0};
    vt[19] = '{1'b0, 32'h1000_0000, 32'h0,  4'h0, ERR, 32'h0};
    vt[20] = '{1'b1, 32'h00, 32'h5A,        4'h2, OK,  32'h0};
    vt[21] = '{1'b0, 32'h00, 32'h0,         4'h0, OK,  32'hA5};

    ARESETn = 1'b0;
    S_AWADDR = '0; S_AWVALID = 1'b0; S_WDATA = '0; S_WSTRB = '0; S_WVALID = 1'b0;
    S_BREADY = 1'b1; S_ARADDR = '0; S_ARVALID = 1'b0; S_RREADY = 1'b1;
    repeat (3) @(posedge ACLK);
    #1 ARESETn = 1'b1;

    @(negedge ACLK);
    chk("rst_awready", 32'(S_AWREADY), 32'd1);
    chk("rst_wready",  32'(S_WREADY),  32'd1);
    chk("rst_arready", 32'(S_ARREADY), 32'd1);
    chk("rst_bvalid",  32'(S_BVALID),  32'd0);
    chk("rst_rvalid",  32'(S_RVALID),  32'd0);
    chk("rst_rdata",   S_RDATA,        32'd0);
    chk("rst_led",     32'(LED_OUT),   32'd0);
    chk("rst_seg",     32'(SEVENSEG_OUT), 32'd0);
    chk("rst_irq",     32'(IRQ_OUT),   32'd0);

    // Reset with an address held but no data: the held address must vanish
    @(posedge ACLK); #1;
    S_AWADDR = 32'h0; S_AWVALID = 1'b1;
    @(posedge ACLK); #1 S_AWVALID = 1'b0;
    @(negedge ACLK);
    chk("aw_held_awready", 32'(S_AWREADY), 32'd0);
    @(posedge ACLK); #1 ARESETn = 1'b0;
    @(posedge ACLK); #1 ARESETn = 1'b1;
    @(negedge ACLK);
    chk("midrst_bvalid",  32'(S_BVALID),  32'd0);
    chk("midrst_awready", 32'(S_AWREADY), 32'd1);
    chk("midrst_led",     32'(LED_OUT),   32'd0);
    @(posedge ACLK); #1;
    S_WDATA = 32'h77; S_WSTRB = 4'h1; S_WVALID = 1'b1;
    @(posedge ACLK); #1 S_WVALID = 1'b0;
    repeat (3) begin
      @(negedge ACLK);
      chk("w_only_bvalid", 32'(S_BVALID), 32'd0);
    end
    chk("w_only_led", 32'(LED_OUT), 32'd0);
    @(posedge ACLK); #1;
    bq.push_back(OK);
    S_AWADDR = 32'h0; S_AWVALID = 1'b1;
    @(posedge ACLK); #1 S_AWVALID = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("late_aw_led", 32'(LED_OUT), 32'h77);
    @(posedge ACLK); #1;

    // AW early, W three cycles later, response back-pressured
    S_BREADY = 1'b0;
    S_AWADDR = 32'h0; S_AWVALID = 1'b1;
    @(posedge ACLK); #1 S_AWVALID = 1'b0;
    @(negedge ACLK);
    chk("bp_awready_held", 32'(S_AWREADY), 32'd0);
    chk("bp_wready_idle",  32'(S_WREADY),  32'd1);
    @(posedge ACLK);
    @(posedge ACLK); #1;
    S_WDATA = 32'hA5; S_WSTRB = 4'h1; S_WVALID = 1'b1;
    @(posedge ACLK); #1 S_WVALID = 1'b0;
    @(negedge ACLK);
    chk("bp_bvalid_pre", 32'(S_BVALID), 32'd0);
    chk("bp_wready_held", 32'(S_WREADY), 32'd0);
    @(posedge ACLK);
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      chk("bp_bvalid", 32'(S_BVALID), 32'd1);
      chk("bp_bresp",  32'(S_BRESP),  32'd0);
      chk("bp_awready", 32'(S_AWREADY), 32'd0);
      chk("bp_wready",  32'(S_WREADY),  32'd0);
      chk("bp_led",    32'(LED_OUT),  32'hA5);
      @(posedge ACLK);
    end
    #1;
    bq.push_back(OK);
    S_BREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("bp_bvalid_done", 32'(S_BVALID), 32'd0);
    chk("bp_awready_back", 32'(S_AWREADY), 32'd1);
    chk("bp_wready_back",  32'(S_WREADY),  32'd1);
    @(posedge ACLK); #1;

    // Register map vectors
    for (int i = 0; i < 22; i++) begin
      if (vt[i].wr) wr(vt[i].addr, vt[i].data, vt[i].strb, vt[i].resp);
      else          rd(vt[i].addr, vt[i].rdata, vt[i].resp);
    end
    chk("tbl_led", 32'(LED_OUT), 32'hA5);
    chk("tbl_seg", 32'(SEVENSEG_OUT), 32'h3C);

    // Timer countdown, expiry and interrupt timing
    wr(32'h0C, 32'h3, 4'h3, OK);
    issue_wr(32'h08, 32'h3, 4'h1, OK);
    for (int i = 0; i < 12; i++) begin
      @(posedge ACLK); #1;
      if (i == 0 || i == 2 || i == 5 || i == 7) begin
        rq.push_back(mk_r(OK, 32'(3 - (i % 4))));
        S_ARADDR = 32'h14; S_ARVALID = 1'b1;
      end else begin
        S_ARVALID = 1'b0;
      end
      @(negedge ACLK);
      chk("tmr_irq", 32'(IRQ_OUT), 32'(i >= 5));
      if (S_ARVALID) chk("tmr_arready", 32'(S_ARREADY), 32'd1);
    end
    @(posedge ACLK); #1 S_ARVALID = 1'b0;
    wr(32'h08, 32'h2, 4'h1, OK);
    rd(32'h10, 32'h1, OK);
    issue_wr(32'h10, 32'h1, 4'h1, OK);
    @(posedge ACLK);
    @(negedge ACLK);
    chk("w1c_irq_commit", 32'(IRQ_OUT), 32'd1);
    @(posedge ACLK);
    @(negedge ACLK);
    chk("w1c_irq_clear", 32'(IRQ_OUT), 32'd0);
    @(posedge ACLK); #1;
    rd(32'h10, 32'h0, OK);

    // Clear landing on the expiry edge loses to the set
    issue_wr(32'h08, 32'h3, 4'h1, OK);
    repeat (3) begin @(posedge ACLK); #1; end
    issue_wr(32'h10, 32'h1, 4'h1, OK);
    @(posedge ACLK);
    @(negedge ACLK);
    chk("race_irq_pre", 32'(IRQ_OUT), 32'd0);
    for (int j = 5; j <= 8; j++) begin
      @(posedge ACLK);
      @(negedge ACLK);
      chk("race_irq", 32'(IRQ_OUT), 32'd1);
    end
    @(posedge ACLK); #1;
    rd(32'h10, 32'h1, OK);

    // LOAD=0 while running: counter drains to zero and never expires again
    wr(32'h0C, 32'h0, 4'h3, OK);
    repeat (8) @(posedge ACLK);
    #1;
    wr(32'h10, 32'h1, 4'h1, OK);
    repeat (10) @(posedge ACLK);
    @(negedge ACLK);
    chk("load0_irq", 32'(IRQ_OUT), 32'd0);
    @(posedge ACLK); #1;
    rd(32'h10, 32'h0, OK);

    // Back-to-back reads with RREADY held high
    S_ARADDR = 32'h00; S_ARVALID = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      chk("b2b_arready", 32'(S_ARREADY), 32'((k % 2) == 0));
      if (k == 0) rq.push_back(mk_r(OK, 32'hA5));
      if (k == 2) rq.push_back(mk_r(OK, 32'h0));
      @(posedge ACLK); #1;
      if (k == 0) S_ARADDR = 32'h14;
      if (k == 2) S_ARVALID = 1'b0;
    end
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("bq_drained", 32'(bq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
